// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative restoring divide.
// Define ALU_MC_MUL_EN to add an iterative shift-add multiplier for op 8.
module alu_mc #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic [3:0]       ccr
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam int CW = $clog2(WIDTH);

   localparam logic [3:0] OP_MUL = 4'd8;
   localparam logic [3:0] OP_DIV = 4'd9;
   localparam logic [3:0] OP_MOD = 4'd10;

   logic [1:0]       state;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] acc, quo, opnd;
   logic [CW-1:0]    count;

   logic [WIDTH:0]   add_w, sub_w;
   logic [WIDTH-1:0] f_res, f_hi;
   logic [3:0]       f_ccr;
   logic             f_long;
   logic             fn, fz, fv, fc;

   always_comb begin
      add_w  = {1'b0, a} + {1'b0, b};
      sub_w  = {1'b0, a} - {1'b0, b};
      f_res  = result;
      f_hi   = result_hi;
      f_long = 1'b0;
      fn     = ccr[3];
      fz     = ccr[2];
      fv     = ccr[1];
      fc     = ccr[0];
      case (op)
         4'd0: begin f_res = a;       f_hi = '0; fv = 1'b0; end
         4'd1: begin f_res = b;       f_hi = '0; fv = 1'b0; end
         4'd2: begin f_res = ~a;      f_hi = '0; fv = 1'b0; end
         4'd3: begin f_res = a & b;   f_hi = '0; fv = 1'b0; end
         4'd4: begin f_res = a | b;   f_hi = '0; fv = 1'b0; end
         4'd5: begin f_res = a ^ b;   f_hi = '0; fv = 1'b0; end
         4'd6: begin
            f_res = add_w[WIDTH-1:0];
            f_hi  = '0;
            fc    = add_w[WIDTH];
            fv    = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
         end
         4'd7: begin
            f_res = sub_w[WIDTH-1:0];
            f_hi  = '0;
            fc    = sub_w[WIDTH];
            fv    = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
         end
`ifdef ALU_MC_MUL_EN
         4'd8: f_long = 1'b1;
`endif
         4'd9, 4'd10: begin
            // Divide by zero completes immediately with a saturated quotient.
            if (b == '0) begin
               f_res = '1;
               f_hi  = a;
               fv    = 1'b1;
            end else begin
               f_long = 1'b1;
            end
         end
         4'd11: fc = 1'b0;
         4'd12: fc = 1'b1;
         default: begin f_res = '0; f_hi = '0; fv = 1'b1; end
      endcase
      if (op != 4'd11 && op != 4'd12) begin
         fn = f_res[WIDTH-1];
         fz = (f_res == '0);
      end
      f_ccr = {fn, fz, fv, fc};
   end

   logic [WIDTH:0]   shifted, diff;
   logic [WIDTH-1:0] acc_nx, quo_nx, l_res, l_hi;
   logic [3:0]       l_ccr;
`ifdef ALU_MC_MUL_EN
   logic [WIDTH:0]   msum;
`endif

   // One iteration of restoring division (or shift-add multiply) per cycle.
   always_comb begin
      shifted = {acc, quo[WIDTH-1]};
      diff    = shifted - {1'b0, opnd};
      if (!diff[WIDTH]) begin
         acc_nx = diff[WIDTH-1:0];
         quo_nx = {quo[WIDTH-2:0], 1'b1};
      end else begin
         acc_nx = shifted[WIDTH-1:0];
         quo_nx = {quo[WIDTH-2:0], 1'b0};
      end
`ifdef ALU_MC_MUL_EN
      msum = {1'b0, acc} + (quo[0] ? {1'b0, opnd} : '0);
      if (op_q == OP_MUL) begin
         acc_nx = msum[WIDTH:1];
         quo_nx = {msum[0], quo[WIDTH-1:1]};
      end
`endif
      l_res = (op_q == OP_MOD) ? acc_nx : quo_nx;
      l_hi  = (op_q == OP_MOD) ? quo_nx : acc_nx;
      l_ccr = {l_res[WIDTH-1], (l_res == '0), 1'b0, ccr[0]};
`ifdef ALU_MC_MUL_EN
      if (op_q == OP_MUL)
         l_ccr = {acc_nx[WIDTH-1], ({acc_nx, quo_nx} == '0), (acc_nx != '0), ccr[0]};
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         result_hi <= '0;
         ccr       <= 4'b0100;
         op_q      <= '0;
         acc       <= '0;
         quo       <= '0;
         opnd      <= '0;
         count     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op_q  <= op;
                  count <= '0;
                  if (f_long) begin
                     state <= CALC;
                     busy  <= 1'b1;
                     acc   <= '0;
                     quo   <= a;
                     opnd  <= b;
                  end else begin
                     state     <= DONE;
                     done      <= 1'b1;
                     result    <= f_res;
                     result_hi <= f_hi;
                     ccr       <= f_ccr;
                  end
               end
            end
            CALC: begin
               acc   <= acc_nx;
               quo   <= quo_nx;
               count <= count + 1'b1;
               if (count == CW'(WIDTH - 1)) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  result    <= l_res;
                  result_hi <= l_hi;
                  ccr       <= l_ccr;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=16): directed corner cases plus
// random transactions compared against an arithmetic reference model.
module tb_alu_mc;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [3:0]  op;
   logic [15:0] a, b;
   logic        busy, done;
   logic [15:0] result, result_hi;
   logic [3:0]  ccr;

   int          n_checks;
   int          n_fails;

   logic [15:0] m_res, m_hi;
   logic [3:0]  m_ccr;

   alu_mc #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .result_hi (result_hi),
      .ccr       (ccr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Expected outcome computed straight from the operation definitions.
   task automatic model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                        output logic [15:0] r, output logic [15:0] h,
                        output logic [3:0] c, output int lat);
      int          t, sx, sy;
      logic [31:0] p;
      logic        n, z, v, cf;
      r = m_res; h = m_hi;
      n = m_ccr[3]; z = m_ccr[2]; v = m_ccr[1]; cf = m_ccr[0];
      lat = 1;
      p = {16'h0, x} * {16'h0, y};
      sx = int'($signed(x));
      sy = int'($signed(y));
      case (o)
         4'd0: begin r = x;     h = 0; v = 0; end
         4'd1: begin r = y;     h = 0; v = 0; end
         4'd2: begin r = ~x;    h = 0; v = 0; end
         4'd3: begin r = x & y; h = 0; v = 0; end
         4'd4: begin r = x | y; h = 0; v = 0; end
         4'd5: begin r = x ^ y; h = 0; v = 0; end
         4'd6: begin
            t = int'(x) + int'(y);
            r = t[15:0]; h = 0;
            cf = (t > 65535);
            v = (sx + sy > 32767) || (sx + sy < -32768);
         end
         4'd7: begin
            r = x - y; h = 0;
            cf = (x < y);
            v = (sx - sy > 32767) || (sx - sy < -32768);
         end
`ifdef ALU_MC_MUL_EN
         4'd8: begin r = p[15:0]; h = p[31:16]; v = (h != 0); lat = 17; end
`endif
         4'd9, 4'd10: begin
            if (y == 0) begin
               r = 16'hFFFF; h = x; v = 1;
            end else begin
               r = (o == 4'd9) ? x / y : x % y;
               h = (o == 4'd9) ? x % y : x / y;
               v = 0; lat = 17;
            end
         end
         4'd11: cf = 0;
         4'd12: cf = 1;
         default: begin r = 0; h = 0; v = 1; end
      endcase
      if (o != 4'd11 && o != 4'd12) begin
         n = r[15];
         z = (r == 0);
      end
`ifdef ALU_MC_MUL_EN
      if (o == 4'd8) begin
         n = h[15];
         z = (p == 0);
      end
`endif
      c = {n, z, v, cf};
   endtask

   task automatic applyStimulus(input logic [3:0] op_i, input logic [15:0] a_i,
                                input logic [15:0] b_i, input bit poke);
      logic [15:0] er, eh;
      logic [3:0]  ec;
      int          el, cyc, busy_cnt;
      bit          seen;
      model(op_i, a_i, b_i, er, eh, ec, el);
      @(negedge clk);
      start = 1'b1; op = op_i; a = a_i; b = b_i;
      @(negedge clk);
      cyc = 1; busy_cnt = 0; seen = 0;
      while (cyc <= 40) begin
         if (done) begin
            seen = 1;
            break;
         end
         if (busy) busy_cnt++;
         // A start raised mid-calculation must be dropped.
         start = poke && (cyc == 5);
         op = 4'd1; a = $urandom; b = $urandom;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      checkOutput($sformatf("done_seen op%0d", op_i), 32'(seen), 32'd1);
      checkOutput($sformatf("latency op%0d", op_i), cyc, el);
      checkOutput($sformatf("busy_cycles op%0d", op_i), busy_cnt, el - 1);
      checkOutput($sformatf("result op%0d", op_i), 32'(result), 32'(er));
      checkOutput($sformatf("result_hi op%0d", op_i), 32'(result_hi), 32'(eh));
      checkOutput($sformatf("ccr op%0d", op_i), 32'(ccr), 32'(ec));
      m_res = er; m_hi = eh; m_ccr = ec;
      @(negedge clk);
      checkOutput("done_pulse_width", 32'(done), 32'd0);
      checkOutput("result_hold", 32'(result), 32'(m_res));
   endtask

   initial begin
      logic [3:0]  r_op;
      logic [15:0] r_a, r_b;
      n_checks = 0; n_fails = 0;
      rst_n = 1'b0; start = 1'b0; op = 4'd0; a = 16'h0; b = 16'h0;
      m_res = 16'h0; m_hi = 16'h0; m_ccr = 4'b0100;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_result", 32'(result), 32'd0);
      checkOutput("reset_result_hi", 32'(result_hi), 32'd0);
      checkOutput("reset_ccr", 32'(ccr), 32'b0100);

      applyStimulus(4'd6, 16'h7FFF, 16'h0001, 0);
      checkOutput("add_ovf_ccr", 32'(ccr), 32'b1010);
      applyStimulus(4'd7, 16'h0000, 16'h0001, 0);
      checkOutput("sub_borrow_ccr", 32'(ccr), 32'b1001);
      applyStimulus(4'd11, 16'h1234, 16'h5678, 0);
      checkOutput("clr_c_result", 32'(result), 32'h0000FFFF);
      checkOutput("clr_c_ccr", 32'(ccr), 32'b1000);
      applyStimulus(4'd9, 16'd100, 16'd7, 1);
      checkOutput("div_quot", 32'(result), 32'd14);
      checkOutput("div_rem", 32'(result_hi), 32'd2);
      applyStimulus(4'd10, 16'd100, 16'd7, 0);
      applyStimulus(4'd9, 16'd5, 16'd0, 0);
      applyStimulus(4'd8, 16'h1234, 16'h0100, 0);
      applyStimulus(4'd12, 16'h0, 16'h0, 0);
      applyStimulus(4'd14, 16'hAAAA, 16'h5555, 0);

      // Reset in the middle of a divide, with a start in the reset cycle.
      @(negedge clk);
      start = 1'b1; op = 4'd9; a = 16'd100; b = 16'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0; start = 1'b1; op = 4'd0; a = 16'h0055;
      @(negedge clk);
      rst_n = 1'b1; start = 1'b0;
      m_res = 16'h0; m_hi = 16'h0; m_ccr = 4'b0100;
      checkOutput("abort_done", 32'(done), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_result", 32'(result), 32'd0);
      checkOutput("abort_ccr", 32'(ccr), 32'b0100);
      repeat (20) begin
         @(negedge clk);
         checkOutput("abort_no_done", 32'(done), 32'd0);
      end
      applyStimulus(4'd9, 16'hFFFF, 16'h0003, 0);

      for (int i = 0; i < 60; i++) begin
         r_op = 4'($urandom_range(0, 15));
         r_a  = 16'($urandom);
         r_b  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
         applyStimulus(r_op, r_a, r_b, ($urandom_range(0, 3) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
